// File: rtl/conta_pkg.sv
// Shared definitions for the up/down modulo counter family.
package conta_pkg;

  // Count direction as seen on the dir input.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned N_DEF   = 8;
  localparam int unsigned P_W_DEF = 4;

endpackage

// File: rtl/conta_presc.sv
// Programmable prescaler: emits tick once every presc+1 enabled cycles.
module conta_presc
  import conta_pkg::*;
#(
  parameter int unsigned P_W = P_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           enable,
  input  logic [P_W-1:0] presc,
  output logic           tick
);

  logic [P_W-1:0] pc;
  logic           hit;

  // An exact match is required; a presc lowered below pc lets pc roll over first.
  assign hit  = (pc == presc);
  assign tick = enable & hit;

  // Prescaler count: restarts on match, freezes while disabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (clear) begin
      pc <= '0;
    end else if (enable) begin
      pc <= hit ? '0 : pc + 1'b1;
    end
  end

endmodule

// File: rtl/conta_updown_mod_param.sv
// Modulo-(M+1) up/down counter with load, prescaler, cascade carry and wrap pulse.
module conta_updown_mod_param
  import conta_pkg::*;
#(
  parameter int unsigned N   = N_DEF,
  parameter int unsigned P_W = P_W_DEF
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           dir,
  input  logic           load,
  input  logic [N-1:0]   d,
  input  logic [N-1:0]   M,
  input  logic [P_W-1:0] presc,
  output logic [N-1:0]   q,
  output logic           tc,
  output logic           wrap
);

  logic         tick;
  logic         dir_up;
  logic         up_wrap;
  logic         dn_wrap;
  logic [N-1:0] q_next;

  conta_presc #(
    .P_W(P_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .enable(enable),
    .presc (presc),
    .tick  (tick)
  );

  assign dir_up  = (dir == DIR_UP);
  // Out-of-range values (q > M) always take the wrap path, so +1/-1 never overflow.
  assign up_wrap = (q >= M);
  assign dn_wrap = (q == '0) || (q > M);

  // Terminal count: high in exactly the cycle whose edge wraps the counter.
  always_comb begin
    tc = 1'b0;
    if (tick && !reset && !load) begin
      tc = dir_up ? up_wrap : dn_wrap;
    end
  end

  // Next count on a tick.
  always_comb begin
    q_next = q;
    if (tick) begin
      if (dir_up) begin
        q_next = up_wrap ? '0 : q + 1'b1;
      end else begin
        q_next = dn_wrap ? M : q - 1'b1;
      end
    end
  end

  // Count register: reset > load > tick > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q_next;
    end
  end

  // Wrap pulse: registered copy of tc.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc;
    end
  end

endmodule

// File: tb/tb_conta_updown_mod_param.sv
// Self-checking bench for conta_updown_mod_param, plus a two-digit decimal cascade.
module tb_conta_updown_mod_param;

  logic       clk;
  logic       reset, load, enable, dir;
  logic [7:0] d, M;
  logic [3:0] presc;
  logic [7:0] q;
  logic       tc, wrap;

  // cascade pair (4-bit digits)
  logic       c_reset, c_en;
  logic [3:0] c_zero, c_nine;
  logic [1:0] c_presc;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, hi_tc, lo_wrap, hi_wrap;

  int checks = 0;
  int errors = 0;

  // reference model state
  int mq, mpc, mwrap;
  bit chk_en;

  conta_updown_mod_param #(.N(8), .P_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .load(load),
    .d(d), .M(M), .presc(presc), .q(q), .tc(tc), .wrap(wrap)
  );

  conta_updown_mod_param #(.N(4), .P_W(2)) u_lo (
    .clk(clk), .reset(c_reset), .enable(c_en), .dir(1'b1), .load(1'b0),
    .d(c_zero), .M(c_nine), .presc(c_presc), .q(lo_q), .tc(lo_tc), .wrap(lo_wrap)
  );

  conta_updown_mod_param #(.N(4), .P_W(2)) u_hi (
    .clk(clk), .reset(c_reset), .enable(lo_tc), .dir(1'b1), .load(1'b0),
    .d(c_zero), .M(c_nine), .presc(c_presc), .q(hi_q), .tc(hi_tc), .wrap(hi_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cyc(input bit r, input bit ld, input bit en, input bit dr,
                     input int dv, input int mv, input int pv);
    int  tick_e, nxt, plain, exp_tc;
    @(negedge clk);
    reset = r; load = ld; enable = en; dir = dr;
    d = dv[7:0]; M = mv[7:0]; presc = pv[3:0];
    #1;
    tick_e = (en && mpc == pv) ? 1 : 0;
    // sequence 0..mv as a ring; out-of-range values jump to the entry point
    if (dr) nxt = (mq > mv) ? 0  : (mq + 1) % (mv + 1);
    else    nxt = (mq > mv) ? mv : (mq + mv) % (mv + 1);
    plain  = dr ? mq + 1 : mq - 1;
    exp_tc = (!r && !ld && tick_e != 0 && (mq > mv || nxt != plain)) ? 1 : 0;
    if (chk_en) begin
      checks++;
      assert (q === mq[7:0]) else begin
        errors++; $error("FAIL q observed=%0d expected=%0d", q, mq);
      end
      checks++;
      assert (tc === exp_tc[0]) else begin
        errors++; $error("FAIL tc observed=%b expected=%0d (q=%0d M=%0d dir=%0d)", tc, exp_tc, mq, mv, dr);
      end
      checks++;
      assert (wrap === mwrap[0]) else begin
        errors++; $error("FAIL wrap observed=%b expected=%0d", wrap, mwrap);
      end
    end
    @(posedge clk);
    if (r) begin
      mq = 0; mpc = 0; mwrap = 0;
    end else if (ld) begin
      mq = dv % 256; mpc = 0; mwrap = 0;
    end else begin
      mwrap = exp_tc;
      if (en) begin
        if (tick_e != 0) mq = nxt;
        mpc = (mpc == pv) ? 0 : (mpc + 1) % 16;
      end
    end
    chk_en = 1'b1;
  endtask

  initial begin
    int mcur, pcur, cnt, elo_tc, ehi_tc, elo_w, ehi_w;
    reset = 1'b1; load = 1'b0; enable = 1'b0; dir = 1'b1;
    d = '0; M = '0; presc = '0;
    c_reset = 1'b1; c_en = 1'b0; c_zero = 4'd0; c_nine = 4'd9; c_presc = 2'd0;
    mq = 0; mpc = 0; mwrap = 0; chk_en = 1'b0;

    // reset (first cycle: q still unknown, not checked)
    cyc(1, 0, 0, 1, 0, 5, 0);
    cyc(1, 0, 1, 1, 0, 5, 0);

    // up count M=5
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, 1, 0, 5, 0);

    // load out-of-range 9, then count down
    cyc(0, 1, 1, 0, 9, 5, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 5, 0);

    // prescaler 2, M=3 up, with an enable gap of 4 cycles
    cyc(0, 1, 1, 1, 0, 3, 2);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1, 0, 3, 2);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 0, 3, 2);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 0, 3, 2);

    // presc lowered below the current prescaler count
    cyc(0, 1, 1, 1, 0, 9, 6);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0, 9, 6);
    for (int i = 0; i < 14; i++) cyc(0, 0, 1, 1, 0, 9, 1);

    // load together with a wrapping tick, then reset together with load
    cyc(0, 1, 1, 1, 5, 5, 0);
    cyc(0, 1, 1, 1, 2, 5, 0);
    cyc(0, 0, 1, 1, 0, 5, 0);
    cyc(0, 0, 1, 1, 0, 5, 0);
    cyc(0, 0, 1, 1, 0, 5, 0);
    cyc(0, 0, 1, 1, 0, 5, 0);
    cyc(1, 1, 1, 1, 7, 5, 0);
    cyc(0, 0, 0, 1, 0, 5, 0);

    // M=0 both directions, also with a prescaler
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0, 1);

    // full range M=255 from 254 up, then down through 0
    cyc(0, 1, 1, 1, 254, 255, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 1, 0, 255, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 0, 255, 0);

    // randomized traffic
    mcur = 5; pcur = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 5))
          0: mcur = 0;
          1: mcur = 1;
          2: mcur = 9;
          3: mcur = 255;
          default: mcur = $urandom_range(0, 255);
        endcase
      end
      if ($urandom_range(0, 24) == 0) pcur = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
          $urandom_range(0, 255), mcur, pcur);
    end
    enable = 1'b0; load = 1'b0; reset = 1'b0;

    // decimal cascade 00..99
    @(negedge clk);
    c_reset = 1'b1; c_en = 1'b0;
    @(posedge clk);
    cnt = 0; elo_w = 0; ehi_w = 0;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      c_reset = 1'b0;
      c_en = ($urandom_range(0, 4) != 0);
      #1;
      elo_tc = (c_en && cnt % 10 == 9) ? 1 : 0;
      ehi_tc = (c_en && cnt == 99) ? 1 : 0;
      checks++;
      assert (lo_q === 4'(cnt % 10)) else begin
        errors++; $error("FAIL cascade_lo observed=%0d expected=%0d", lo_q, cnt % 10);
      end
      checks++;
      assert (hi_q === 4'(cnt / 10)) else begin
        errors++; $error("FAIL cascade_hi observed=%0d expected=%0d", hi_q, cnt / 10);
      end
      checks++;
      assert (lo_tc === elo_tc[0] && hi_tc === ehi_tc[0]) else begin
        errors++; $error("FAIL cascade_tc observed=%b%b expected=%0d%0d", hi_tc, lo_tc, ehi_tc, elo_tc);
      end
      checks++;
      assert (lo_wrap === elo_w[0] && hi_wrap === ehi_w[0]) else begin
        errors++; $error("FAIL cascade_wrap observed=%b%b expected=%0d%0d", hi_wrap, lo_wrap, ehi_w, elo_w);
      end
      @(posedge clk);
      elo_w = elo_tc; ehi_w = ehi_tc;
      if (c_en) cnt = (cnt + 1) % 100;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conta_updown_mod_param.md
# conta_updown_mod_param

Parametrised modulo-(M+1) counter with up/down direction, synchronous parallel load, a programmable prescaler, a terminal-count carry for cascading and a registered wrap pulse. It generalises the fixed-width up counter with enable and synchronous reset. It is used as the timebase and sequencing counter in the digital-systems lab designs, either alone or cascaded through `tc` into the next stage's `enable`.

## Interface
- `N`, default 8: counter and modulus width in bits (N ≥ 2).
- `P_W`, default 4: prescaler width in bits (P_W ≥ 1).

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high reset. One clock; the reset polarity and synchronicity are fixed.
- `enable` input 1: count enable; freezes both the counter and the prescaler when low.
- `dir` input 1: direction; 1 counts up, 0 counts down.
- `load` input 1: synchronous parallel load.
- `d` input N: load value.
- `M` input N: maximum count; the sequence spans 0..M.
- `presc` input P_W: prescaler divide value; the counter advances once every `presc`+1 enabled cycles.
- `q` output N: current count.
- `tc` output 1: combinational terminal-count carry.
- `wrap` output 1: registered one-cycle pulse that follows a wrap.

## Operation
- Priority at each rising edge: `reset` > `load` > (`enable` & `tick`) > hold.
- Reset:
  - `q`=0, prescaler count `pc`=0, `wrap`=0.
  - `tc` reads 0 while `enable`=0.
- Load:
  - `q`←`d`, `pc`←0, `wrap`←0.
  - `d` is accepted even when `d` > `M`. `enable` is ignored during a load.
- Prescaler:
  - `tick` = `enable` & (`pc`==`presc`).
  - On every enabled cycle: `pc`←0 if `pc`==`presc`, else `pc`+1.
  - `presc`=0 gives a tick on every enabled cycle, which is plain enable behaviour.
  - If `presc` is changed below the current `pc`, `pc` counts up to 2^P_W−1, wraps to 0, and then matches `presc`.
- Count on `tick`, up (`dir`=1):
  - `q`≥`M` → 0.
  - Otherwise `q`+1.
- Count on `tick`, down (`dir`=0):
  - `q`==0 or `q`>`M` → `M`.
  - Otherwise `q`−1.
- Terminal count:
  - `tc` = `tick` & ((`dir` & `q`≥`M`) | (!`dir` & (`q`==0 | `q`>`M`))).
  - `tc` is high exactly in the cycle whose edge wraps the counter.
  - `tc` is forced low while `reset` or `load` is high.
- Wrap: `wrap`←`tc` on each edge.
- Arithmetic:
  - All comparisons are unsigned N-bit.
  - `q`+1 and `q`−1 never overflow, because wraps are handled by the compares above.
- `M`=0: `q` stays at 0 and `tc` pulses on every tick in either direction.
- Changing `dir` or `M` mid-count takes effect at the next tick. No state is reset.

## Timing
- Every register updates on the rising edge of `clk`. No asynchronous paths.
- `q` changes 1 cycle after a qualifying edge's inputs. Load latency is 1 cycle.
- `tc` is combinational from `q`, `pc`, `M`, `dir`, `enable`, `reset` and `load`, so it is valid in the same cycle. `tc` feeds the next stage's `enable` directly with zero added latency.
- `wrap` is asserted in the cycle after `tc`, for exactly 1 cycle per wrap.
- Reset applied mid-count clears all state at that edge. Counting resumes on the first enabled cycle after `reset` falls, with the prescaler starting from 0.

## Structure
- Shared package `conta_pkg`:
  - Direction constants `DIR_UP`=1'b1 and `DIR_DOWN`=1'b0.
  - Defaults for `N` and `P_W`.
- Sub-module `conta_presc`:
  - Contains the prescaler register and its compare.
  - Ports: `clk`, `reset`, `clear` (driven by `load`), `enable`, `presc`, `tick`.
- The top level holds the `q` register, the next-state mux, the `tc` logic and the `wrap` register.

## Test plan
- Reset and up count: `reset`, then `M`=5, `dir`=1, `presc`=0, `enable`=1 → `q` follows 0,1,2,3,4,5,0,1…; `tc` is high while `q`=5; `wrap` is high the cycle after `q` returns to 0.
- Down count with out-of-range load: load `d`=9 with `M`=5, then `dir`=0 → `q` follows 9,5,4,3,2,1,0,5…; `tc` is high at `q`=9 and at `q`=0.
- Prescaler: `presc`=2, `M`=3, up → `q` advances every 3rd enabled cycle. Dropping `enable` for 4 cycles freezes both `q` and `pc`.
- Priority and simultaneous events: `load`=1 together with `tick`, and then `reset`=1 together with `load`=1:
  - `load` with `tick` → `q`=`d`, `tc`=0.
  - `reset` with `load` → `q`=0, `wrap`=0.
- Edge cases `M`=0 and full range:
  - `M`=0 → `q` stays 0 and `tc` is high on every tick.
  - `M`=2^N−1 up from 2^N−2 → `q` follows 2^N−2, 2^N−1, 0.
- Cascade: two instances, the high stage's `enable` driven by the low stage's `tc`, both `M`=9 → a decimal 00..99 sequence. The high digit increments exactly when the low digit goes 9→0.
